// File: rtl/alu_unit_if.sv
// alu_unit_if
//   Bundles the ALU's operation-in and result-out handshakes so producer
//   and consumer connect through a single port.
//
//   Parameter:
//     N          datapath width (multiple of 4, at least 4)
//   Signals:
//     in_valid   producer -> ALU   operation on op/a/b is valid
//     in_ready   ALU -> producer   ALU can accept an operation this cycle
//     op         producer -> ALU   3-bit opcode
//     a, b       producer -> ALU   N-bit operands
//     out_valid  ALU -> consumer   result and flags are valid
//     out_ready  consumer -> ALU   consumer takes the result this cycle
//     result     ALU -> consumer   N-bit registered result
//     flags      ALU -> consumer   {N, Z, C, V}
//   Modports:
//     master     the side that issues operations and takes results
//     slave      the ALU itself
interface alu_unit_if #(parameter int N = 16) ();
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_unit.sv
// alu_unit
//   Handshaked ALU. One operation is accepted per in_valid & in_ready
//   transfer; the result and {N,Z,C,V} flags are registered and held until
//   the consumer takes them with out_ready. ADD/SUB go through a chain of
//   4-bit carry-lookahead blocks; AND/OR/XOR/PASSB/NOP are single-cycle.
//
//   Configuration macro: ALU_MULT_EN
//     defined   - op 110 is an unsigned shift-add multiply taking N EXEC
//                 cycles (result appears N+1 cycles after accept).
//     undefined - no multiplier hardware; op 110 behaves exactly as NOP.
//
//   Ports:
//     clk   clock, all state changes on the rising edge
//     rst   synchronous active-high reset
//     bus   alu_unit_if.slave (in_valid/in_ready/op/a/b,
//           out_valid/out_ready/result/flags)
module alu_unit #(
  parameter int N = 16
) (
  input logic        clk,
  input logic        rst,
  alu_unit_if.slave  bus
);

  localparam int NB = N / 4;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;
`ifdef ALU_MULT_EN
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam int         CW       = $clog2(N) + 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MULT_EN
    EXEC = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
`ifdef ALU_MULT_EN
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
`endif

  logic         in_ready;
  logic         accept;

  // Shared adder: SUB feeds ~b with carry-in 1 so C=1 means no borrow.
  logic         add_cin;
  logic [N-1:0] add_y;
  logic [N-1:0] add_sum;
  logic [NB:0]  cy;

  assign add_cin = (bus.op == OP_SUB);
  assign add_y   = add_cin ? ~bus.b : bus.b;
  assign cy[0]   = add_cin;

  for (genvar k = 0; k < NB; k++) begin : g_cla
    logic [3:0] x, y, g, p;
    logic [4:0] c;
    assign x    = bus.a[4*k +: 4];
    assign y    = add_y[4*k +: 4];
    assign g    = x & y;
    assign p    = x ^ y;
    assign c[0] = cy[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign add_sum[4*k +: 4] = p ^ c[3:0];
    assign cy[k+1] = c[4];
  end

  // Single-cycle result and C/V for the presented op. NOP (and op 110 when
  // the multiplier is not built) fall through to the zero default.
  logic [N-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = add_sum;
        alu_c   = cy[NB];
        alu_v   = (bus.a[N-1] == bus.b[N-1]) & (add_sum[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        alu_res = add_sum;
        alu_c   = cy[NB];
        alu_v   = (bus.a[N-1] != bus.b[N-1]) & (add_sum[N-1] != bus.a[N-1]);
      end
      OP_AND:   alu_res = bus.a & bus.b;
      OP_OR:    alu_res = bus.a | bus.b;
      OP_XOR:   alu_res = bus.a ^ bus.b;
      OP_PASSB: alu_res = bus.b;
      default:  alu_res = '0;
    endcase
  end

  // A slot opens when idle, or when the held result is being taken this
  // same cycle. Held low during reset so nothing is accepted then.
  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  // Next-state and datapath. The order matters: draining DONE first, then
  // an EXEC step, then a new accept, which overrides the drain to IDLE.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
`ifdef ALU_MULT_EN
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
`endif

    if ((state_q == DONE) && bus.out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end

`ifdef ALU_MULT_EN
    // One multiplier bit per cycle, LSB first; the last iteration writes
    // the product straight into the output registers.
    if (state_q == EXEC) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = acc_d[N-1:0];
        flags_d     = {acc_d[N-1], (acc_d[N-1:0] == '0),
                       |acc_d[2*N-1:N], |acc_d[2*N-1:N]};
      end
    end
`endif

    if (accept) begin
`ifdef ALU_MULT_EN
      if (bus.op == OP_MUL) begin
        state_d     = EXEC;
        out_valid_d = 1'b0;
        cnt_d       = '0;
        acc_d       = '0;
        mcand_d     = {{N{1'b0}}, bus.a};
        mplier_d    = bus.b;
      end else
`endif
      begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = alu_res;
        flags_d     = {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
`ifdef ALU_MULT_EN
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
`ifdef ALU_MULT_EN
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit
//   Directed-vector bench for alu_unit (N=16). Expected values are worked
//   out by hand from the operand values. Multiply vectors are included only
//   when ALU_MULT_EN is defined; otherwise op 110 is checked as a NOP.
module tb_alu_unit;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  alu_unit_if #(.N(16)) bus ();

  alu_unit #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one operation for a single edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.a        = '0;
    bus.b        = '0;
    bus.out_ready = 1'b1;

    idleCycle();
    idleCycle();
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_result",    32'(bus.result),    32'h0);
    checkOutput("rst_flags",     32'(bus.flags),     32'h0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'h0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 32'(bus.in_ready),  32'h1);

    $display("[TB] single-cycle ops, back to back");
    applyStimulus(OP_ADD, 16'hFFFF, 16'h0001);
    checkOutput("add_valid",  32'(bus.out_valid), 32'h1);
    checkOutput("add_result", 32'(bus.result),    32'h0000);
    checkOutput("add_flags",  32'(bus.flags),     32'h6);
    applyStimulus(OP_SUB, 16'h8000, 16'h0001);
    checkOutput("sub_valid",  32'(bus.out_valid), 32'h1);
    checkOutput("sub_result", 32'(bus.result),    32'h7FFF);
    checkOutput("sub_flags",  32'(bus.flags),     32'h3);
    applyStimulus(OP_SUB, 16'h0001, 16'h0002);
    checkOutput("sub_borrow_result", 32'(bus.result), 32'hFFFF);
    checkOutput("sub_borrow_flags",  32'(bus.flags),  32'h8);
    applyStimulus(OP_ADD, 16'h7FFF, 16'h0001);
    checkOutput("add_ovf_result", 32'(bus.result), 32'h8000);
    checkOutput("add_ovf_flags",  32'(bus.flags),  32'h9);
    applyStimulus(OP_ADD, 16'h1234, 16'h0FCD);
    checkOutput("add_carry_chain", 32'(bus.result), 32'h2201);
    applyStimulus(OP_AND, 16'hF0F0, 16'h3C3C);
    checkOutput("and_result", 32'(bus.result), 32'h3030);
    checkOutput("and_flags",  32'(bus.flags),  32'h0);
    applyStimulus(OP_OR, 16'h8000, 16'h0001);
    checkOutput("or_result", 32'(bus.result), 32'h8001);
    checkOutput("or_flags",  32'(bus.flags),  32'h8);
    applyStimulus(OP_PASSB, 16'hABCD, 16'h0000);
    checkOutput("passb_result", 32'(bus.result), 32'h0000);
    checkOutput("passb_flags",  32'(bus.flags),  32'h4);
    applyStimulus(OP_NOP, 16'h0005, 16'h0006);
    checkOutput("nop_result", 32'(bus.result), 32'h0000);
    checkOutput("nop_flags",  32'(bus.flags),  32'h4);
    idleCycle();
    checkOutput("drained_valid", 32'(bus.out_valid), 32'h0);

    $display("[TB] held result under backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(OP_XOR, 16'hA5A5, 16'hFFFF);
    bus.in_valid = 1'b1;
    bus.op       = OP_PASSB;
    bus.a        = 16'h1111;
    bus.b        = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("hold_valid",    32'(bus.out_valid), 32'h1);
      checkOutput("hold_result",   32'(bus.result),    32'h5A5A);
      checkOutput("hold_flag_n",   32'(bus.flags[3]),  32'h0);
      checkOutput("hold_in_ready", 32'(bus.in_ready),  32'h0);
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b1;
    bus.op = OP_ADD;
    bus.a  = 16'h0002;
    bus.b  = 16'h0003;
    #1;
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'h1);
    idleCycle();
    bus.in_valid = 1'b0;
    checkOutput("release_add_result", 32'(bus.result), 32'h0005);
    checkOutput("release_add_flags",  32'(bus.flags),  32'h0);
    idleCycle();

`ifdef ALU_MULT_EN
    $display("[TB] multiply");
    applyStimulus(OP_MUL, 16'h0012, 16'h0034);
    for (int c = 1; c <= 16; c++) begin
      checkOutput("mul_busy_valid", 32'(bus.out_valid), 32'h0);
      if (c < 16) idleCycle();
      else        begin @(posedge clk); #1; end
    end
    checkOutput("mul_valid",  32'(bus.out_valid), 32'h1);
    checkOutput("mul_result", 32'(bus.result),    32'h03A8);
    checkOutput("mul_flags",  32'(bus.flags),     32'h0);
    applyStimulus(OP_MUL, 16'h0100, 16'h0100);
    for (int c = 1; c <= 16; c++) idleCycle();
    checkOutput("mul_ovf_valid",  32'(bus.out_valid), 32'h1);
    checkOutput("mul_ovf_result", 32'(bus.result),    32'h0000);
    checkOutput("mul_ovf_flags",  32'(bus.flags),     32'h7);
    applyStimulus(OP_PASSB, 16'h0000, 16'h1234);
    idleCycle();

    $display("[TB] reset during multiply");
    applyStimulus(OP_MUL, 16'h0003, 16'h0005);
    for (int c = 1; c < 5; c++) idleCycle();
    rst = 1'b1;
    #1;
    checkOutput("mrst_in_ready_hi", 32'(bus.in_ready), 32'h0);
    idleCycle();
    checkOutput("mrst_valid",  32'(bus.out_valid), 32'h0);
    checkOutput("mrst_result", 32'(bus.result),    32'h0);
    checkOutput("mrst_flags",  32'(bus.flags),     32'h0);
    rst = 1'b0;
    #1;
    checkOutput("mrst_in_ready", 32'(bus.in_ready), 32'h1);
    begin
      logic stale;
      stale = 1'b0;
      for (int c = 0; c < 20; c++) begin
        idleCycle();
        stale = stale | bus.out_valid;
      end
      checkOutput("mrst_no_stale", 32'(stale), 32'h0);
    end
`else
    $display("[TB] op 110 without multiplier");
    applyStimulus(OP_MUL, 16'h0003, 16'h0004);
    checkOutput("op110_valid",  32'(bus.out_valid), 32'h1);
    checkOutput("op110_result", 32'(bus.result),    32'h0000);
    checkOutput("op110_flags",  32'(bus.flags),     32'h4);
    idleCycle();
    checkOutput("op110_drained", 32'(bus.out_valid), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Sequential, handshaked ALU built from the team's combinational primitives: the 4-bit carry-lookahead adder chain, the N-bit AND/OR/XOR gates and the muxes. It sits directly downstream of those primitives and upstream of the register-writeback stage. It accepts one operation per valid/ready transfer and registers the result together with Z/N/C/V flags. An optional multi-cycle shift-add multiplier is built in when the configuration macro is defined.

## Interface
- N, 16, datapath width; must be a multiple of 4 and at least 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the operation on op/a/b is valid.
- in_ready  out  1  the block can accept an operation this cycle.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSB, 110 MUL, 111 NOP.
- a  in  N  operand A.
- b  in  N  operand B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  the consumer takes the result this cycle.
- result  out  N  registered result.
- flags  out  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V.

## Operation
- States:
  - IDLE: no result pending.
  - EXEC: multiply in progress.
  - DONE: result held until it is taken.
- Accept = in_valid & in_ready. a, b and op are sampled only on accept.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is 0 in EXEC and 0 while rst is high.
- Transitions:
  - A single-cycle op on accept goes to DONE.
  - MUL on accept goes to EXEC.
  - EXEC goes to DONE after N iterations.
  - DONE with out_ready and no accept goes to IDLE.
  - DONE with out_ready and accept goes to DONE or EXEC, depending on the new op.
- ADD: a + b + 0 through ceil N/4 chained CLA-4 blocks.
  - C = carry out of the top block.
  - V = (a[N-1]==b[N-1]) & (sum[N-1]!=a[N-1]).
- SUB: a + ~b + 1 on the same adder.
  - C = carry out, so C=1 means no borrow.
  - V = (a[N-1]!=b[N-1]) & (diff[N-1]!=a[N-1]).
- AND, OR, XOR: bitwise operations. C=0, V=0.
- PASSB: result = b. C=0, V=0.
- NOP: result = 0. C=0, V=0.
- Z = (result == 0) and N = result[N-1] for every op.
- MUL (only with the macro): unsigned shift-add, one bit of b per EXEC cycle, LSB first, using a 2N-bit accumulator.
  - result = low N bits of the product.
  - C = V = OR of the high N product bits.
- Reset clears state to IDLE, out_valid=0, result=0, flags=0, and the multiply counter and accumulator to 0.
- Reset while in EXEC or DONE discards the pending operation; no output is produced.
- a, b and op changing while not accepted have no effect.

## Timing
- Cycle 0 is the accept cycle.
- Single-cycle ops: out_valid=1, with result and flags valid, in cycle 1.
- MUL: EXEC occupies cycles 1..N; out_valid=1 in cycle N+1 (cycle 17 for N=16).
- out_valid, result and flags stay stable while out_valid=1 and out_ready=0.
- The result is consumed in the cycle where out_valid & out_ready are both 1.
- Back-to-back single-cycle ops sustain 1 op/cycle while out_ready is held at 1.
- in_ready has a combinational dependency on out_ready; there is no other combinational in-to-out path.
- out_valid, result and flags come directly from registers.

## Configuration
- ALU_MULT_EN defined:
  - EXEC state, multiply counter and 2N-bit accumulator are present.
  - op 110 performs MUL with latency N+1.
- ALU_MULT_EN undefined:
  - No EXEC state and no multiplier hardware.
  - op 110 behaves exactly as NOP: result 0, Z=1, others 0, single cycle.

## Test plan
- ADD, a=0xFFFF, b=0x0001 -> cycle 1: out_valid=1, result=0x0000, flags N=0 Z=1 C=1 V=0.
- SUB, a=0x8000, b=0x0001 -> result=0x7FFF, N=0 Z=0 C=1 V=1.
- XOR 0xA5A5^0xFFFF with out_ready low for 3 cycles:
  - result stays 0x5A5A with N=0 and in_ready=0 throughout.
  - Then out_ready=1 together with an ADD 0x0002+0x0003 presented: the ADD is accepted, next cycle result=0x0005.
- (ALU_MULT_EN) MUL 0x0012*0x0034:
  - out_valid=0 in cycles 1..16; cycle 17: result=0x03A8, C=0.
  - MUL 0x0100*0x0100 -> result=0x0000, Z=1 C=1 V=1.
- (ALU_MULT_EN) rst=1 in cycle 5 of a MUL:
  - out_valid=0, result=0, flags=0 after the reset edge.
  - in_ready=1 once rst is low; no stale result ever appears.
- Without ALU_MULT_EN, op=110 with a=0x0003, b=0x0004 -> cycle 1: result=0x0000, Z=1 C=0 V=0.
